// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to
// instruction memory, buffers responses in order and presents {pc, instr}
// to decode over a valid/ready handshake. A redirect flushes the queue and
// arranges for in-flight responses to be discarded as they return.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcplus4,
  output logic [31:0] if_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Control state
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  ptr_t             fill_q, fill_d;
  cnt_t             alloc_cnt_q, alloc_cnt_d;
  cnt_t             unfilled_cnt_q, unfilled_cnt_d;
  cnt_t             discard_cnt_q, discard_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  // Entry payload (data only, never reset)
  logic [31:0]      ent_pc_q    [DEPTH];
  logic [31:0]      ent_pc_d    [DEPTH];
  logic [31:0]      ent_instr_q [DEPTH];
  logic [31:0]      ent_instr_d [DEPTH];

  // Registered head view presented to decode
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic [31:0]      if_instr_q, if_instr_d;

  logic             accept;
  logic             pop;
  logic             rsp_fill;
  logic             rsp_drop;
  logic [CNT_W:0]   credit_used;
  logic [CNT_W:0]   outstanding;
  logic [CNT_W:0]   rsp_ext;
  logic             unused_redirect_lsbs;

  // The low two redirect bits are forced to zero and otherwise unused.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit uses only registered counts so if_ready never reaches imem_req_valid.
  assign credit_used    = {1'b0, alloc_cnt_q} + {1'b0, discard_cnt_q};
  assign outstanding    = {1'b0, unfilled_cnt_q} + {1'b0, discard_cnt_q};
  assign rsp_ext        = {{CNT_W{1'b0}}, imem_rsp_valid};

  assign imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pop            = if_valid_q && if_ready;
  assign rsp_drop       = imem_rsp_valid && (discard_cnt_q != '0);
  assign rsp_fill       = imem_rsp_valid && (discard_cnt_q == '0);

  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_pcplus4     = if_pc_q + 32'd4;
  assign if_instr       = if_instr_q;

  // Next-state of the queue: redirect flushes, otherwise allocate/fill/pop.
  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    head_d         = head_q;
    tail_d         = tail_q;
    fill_d         = fill_q;
    alloc_cnt_d    = alloc_cnt_q;
    unfilled_cnt_d = unfilled_cnt_q;
    discard_cnt_d  = discard_cnt_q;
    filled_d       = filled_q;
    ent_pc_d       = ent_pc_q;
    ent_instr_d    = ent_instr_q;

    if (redirect_valid) begin
      // Everything still owed by memory becomes a discard, less any
      // response arriving right now (it is dropped here).
      fetch_pc_d     = {redirect_pc[31:2], 2'b00};
      head_d         = '0;
      tail_d         = '0;
      fill_d         = '0;
      alloc_cnt_d    = '0;
      unfilled_cnt_d = '0;
      filled_d       = '0;
      discard_cnt_d  = cnt_t'(outstanding - rsp_ext);
    end else begin
      if (accept) begin
        ent_pc_d[tail_q] = fetch_pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + 1'b1;
        fetch_pc_d       = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        discard_cnt_d = discard_cnt_q - 1'b1;
      end
      // Responses return in order, so they always land on the oldest
      // unfilled entry; that is never the head being popped.
      if (rsp_fill) begin
        ent_instr_d[fill_q] = imem_rsp_data;
        filled_d[fill_q]    = 1'b1;
        fill_d              = fill_q + 1'b1;
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + 1'b1;
      end
      alloc_cnt_d    = alloc_cnt_q + cnt_t'(accept) - cnt_t'(pop);
      unfilled_cnt_d = unfilled_cnt_q + cnt_t'(accept) - cnt_t'(rsp_fill);
    end
  end

  // Head view for the next cycle; pc/instr hold while the head is empty.
  always_comb begin
    if_valid_d = !redirect_valid && filled_d[head_d];
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (if_valid_d) begin
      if_pc_d    = ent_pc_d[head_d];
      if_instr_d = ent_instr_d[head_d];
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q     <= RESET_PC;
      head_q         <= '0;
      tail_q         <= '0;
      fill_q         <= '0;
      alloc_cnt_q    <= '0;
      unfilled_cnt_q <= '0;
      discard_cnt_q  <= '0;
      filled_q       <= '0;
      if_valid_q     <= 1'b0;
      if_pc_q        <= '0;
      if_instr_q     <= '0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      fill_q         <= fill_d;
      alloc_cnt_q    <= alloc_cnt_d;
      unfilled_cnt_q <= unfilled_cnt_d;
      discard_cnt_q  <= discard_cnt_d;
      filled_q       <= filled_d;
      if_valid_q     <= if_valid_d;
      if_pc_q        <= if_pc_d;
      if_instr_q     <= if_instr_d;
    end
  end

  // Entry payload storage; validity is tracked by filled_q, so no reset.
  always_ff @(posedge clk) begin
    ent_pc_q    <= ent_pc_d;
    ent_instr_q <= ent_instr_d;
  end

  // Structural invariants of the credit scheme.
  a_alloc_bound : assert property (@(posedge clk) disable iff (reset)
    ({1'b0, alloc_cnt_q} <= DEPTH_C));
  a_credit_bound : assert property (@(posedge clk) disable iff (reset)
    (credit_used <= DEPTH_C));
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (reset)
    (imem_rsp_valid |-> (outstanding != '0)));

endmodule
